// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with a double-buffered display register,
// per-digit dp/blank/blink, leading-zero suppression and a per-slot ghosting guard.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 1,
    parameter int BLINK_FRAMES = 250,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit DIG_ACT_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    input  logic [NUM_DIGITS-1:0]     blink_in,
    input  logic                      lz_en,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     digit,
    output logic                      busy
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int N  = NUM_DIGITS;

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
    localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic          DP_OFF  = SEG_ACT_LOW ? 1'b1 : 1'b0;
    localparam logic [N-1:0]  DIG_OFF = DIG_ACT_LOW ? {N{1'b1}} : {N{1'b0}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PW-1:0]  p_q, p_d;
    logic [IW-1:0]  i_q, i_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;
    logic           bphase_q, bphase_d;
    logic [4*N-1:0] shd_data_q, shd_data_d, act_data_q, act_data_d;
    logic [N-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
    logic [N-1:0]   shd_blank_q, shd_blank_d, act_blank_q, act_blank_d;
    logic [N-1:0]   shd_blink_q, shd_blink_d, act_blink_q, act_blink_d;
    logic           busy_q, busy_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_q, dp_d;
    logic [N-1:0]   digit_q, digit_d;

    logic           frame_end_s;
    logic [N-1:0]   lz_mask_s;
    logic           zero_run_s;
    logic           dark_s;
    logic [3:0]     cur_nib_s;
    logic [6:0]     seg_hi_s;
    logic           dp_hi_s;
    logic [N-1:0]   dig_hi_s;

    // Scan counters, blink timebase and the shadow/active commit logic
    always_comb begin
        frame_end_s = (p_q == P_LAST) && (i_q == I_LAST);
        p_d         = (p_q == P_LAST) ? {PW{1'b0}} : p_q + PW'(1);
        i_d         = i_q;
        bcnt_d      = bcnt_q;
        bphase_d    = bphase_q;
        shd_data_d  = shd_data_q;   act_data_d  = act_data_q;
        shd_dp_d    = shd_dp_q;     act_dp_d    = act_dp_q;
        shd_blank_d = shd_blank_q;  act_blank_d = act_blank_q;
        shd_blink_d = shd_blink_q;  act_blink_d = act_blink_q;
        busy_d      = busy_q;

        if (p_q == P_LAST) begin
            i_d = (i_q == I_LAST) ? {IW{1'b0}} : i_q + IW'(1);
        end else begin
            i_d = i_q;
        end

        if (frame_end_s) begin
            if (bcnt_q == B_LAST) begin
                bcnt_d   = {BW{1'b0}};
                bphase_d = ~bphase_q;
            end else begin
                bcnt_d   = bcnt_q + BW'(1);
            end
        end else begin
            bcnt_d = bcnt_q;
        end

        // A load landing on the frame-end cycle goes straight to the active set.
        if (load && frame_end_s) begin
            act_data_d  = data;      act_dp_d    = dp_in;
            act_blank_d = blank_in;  act_blink_d = blink_in;
            busy_d      = 1'b0;
        end else if (load) begin
            shd_data_d  = data;      shd_dp_d    = dp_in;
            shd_blank_d = blank_in;  shd_blink_d = blink_in;
            busy_d      = 1'b1;
        end else if (frame_end_s && busy_q) begin
            act_data_d  = shd_data_q;   act_dp_d    = shd_dp_q;
            act_blank_d = shd_blank_q;  act_blink_d = shd_blink_q;
            busy_d      = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // Output decode for the slot currently addressed by (p, i)
    always_comb begin
        zero_run_s = 1'b1;
        lz_mask_s  = {N{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            zero_run_s   = zero_run_s & (act_data_q[4*k +: 4] == 4'h0);
            lz_mask_s[k] = zero_run_s;
        end
        cur_nib_s = act_data_q[{i_q, 2'b00} +: 4];
        dark_s    = act_blank_q[i_q]
                  | (act_blink_q[i_q] & bphase_q)
                  | (lz_en & lz_mask_s[i_q] & (i_q != {IW{1'b0}}));
        seg_hi_s  = dark_s ? 7'h00 : hex_to_seg(cur_nib_s);
        dp_hi_s   = ~dark_s & act_dp_q[i_q];
        dig_hi_s  = (p_q >= P_GUARD) ? (N'(1) << i_q) : {N{1'b0}};
        seg_d     = SEG_ACT_LOW ? ~seg_hi_s : seg_hi_s;
        dp_d      = SEG_ACT_LOW ? ~dp_hi_s  : dp_hi_s;
        digit_d   = DIG_ACT_LOW ? ~dig_hi_s : dig_hi_s;
    end

    // State and registered pin drivers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q         <= {PW{1'b0}};
            i_q         <= {IW{1'b0}};
            bcnt_q      <= {BW{1'b0}};
            bphase_q    <= 1'b0;
            shd_data_q  <= {(4*N){1'b0}};  act_data_q  <= {(4*N){1'b0}};
            shd_dp_q    <= {N{1'b0}};      act_dp_q    <= {N{1'b0}};
            shd_blank_q <= {N{1'b0}};      act_blank_q <= {N{1'b0}};
            shd_blink_q <= {N{1'b0}};      act_blink_q <= {N{1'b0}};
            busy_q      <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            digit_q     <= DIG_OFF;
        end else begin
            p_q         <= p_d;
            i_q         <= i_d;
            bcnt_q      <= bcnt_d;
            bphase_q    <= bphase_d;
            shd_data_q  <= shd_data_d;   act_data_q  <= act_data_d;
            shd_dp_q    <= shd_dp_d;     act_dp_q    <= act_dp_d;
            shd_blank_q <= shd_blank_d;  act_blank_q <= act_blank_d;
            shd_blink_q <= shd_blink_d;  act_blink_q <= act_blink_d;
            busy_q      <= busy_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            digit_q     <= digit_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign digit = digit_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: N=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2, active-high pins.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in, blank_in, blink_in;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Bench-side position tracker: (mp, mi) is the scan state, (pp, pi) the state before the last edge
    int mp = 0, mi = 0, pp = 0, pi = 0, mbc = 0, mph = 0;
    logic [6:0] seen0;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2),
        .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .lz_en(lz_en),
        .seg(seg), .dp(dp), .digit(digit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        pp = mp;
        pi = mi;
        if (!rst_n) begin
            mp = 0; mi = 0; mbc = 0; mph = 0;
        end else begin
            if (mp == 3 && mi == 3) begin
                if (mbc == 1) begin
                    mbc = 0;
                    mph = 1 - mph;
                end else begin
                    mbc = mbc + 1;
                end
            end
            if (mp == 3) begin
                mp = 0;
                mi = (mi == 3) ? 0 : mi + 1;
            end else begin
                mp = mp + 1;
            end
        end
        #1;
    endtask

    task automatic wait_fe();
        int n = 0;
        while (!(mp == 3 && mi == 3) && n < 20) begin
            step();
            n++;
        end
        check_eq("wait_frame_end", {31'd0, (mp == 3 && mi == 3)}, 32'd1);
    endtask

    task automatic load_at_fe(input logic [15:0] d, input logic [3:0] dpv,
                              input logic [3:0] blv, input logic [3:0] bkv);
        wait_fe();
        data = d; dp_in = dpv; blank_in = blv; blink_in = bkv; load = 1'b1;
        step();
        load = 1'b0;
        check_eq("fe_load_busy", {31'd0, busy}, 32'd0);
    endtask

    // One full frame starting at slot 0, prescaler 0: guard cycle then three lit cycles per slot
    task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpe);
        logic [6:0] ev [4];
        logic [3:0] de;
        ev[0] = s0; ev[1] = s1; ev[2] = s2; ev[3] = s3;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                de = (c == 0) ? 4'b0000 : (4'b0001 << s);
                check_eq("frame_digit", {28'd0, digit}, {28'd0, de});
                check_eq("frame_seg", {25'd0, seg}, {25'd0, ev[s]});
                check_eq("frame_dp", {31'd0, dp}, {31'd0, dpe[s]});
                if (s == 0 && c == 2) seen0 = seg;
            end
        end
    endtask

    initial begin
        logic [6:0] old_seg [4];
        logic [6:0] e0;
        int         vis;
        bit         done;

        rst_n = 1'b0; load = 1'b1; data = 16'hFFFF;
        dp_in = 4'hF; blank_in = 4'h0; blink_in = 4'h0; lz_en = 1'b0;
        repeat (3) step();
        check_eq("rst_seg", {25'd0, seg}, 32'h00);
        check_eq("rst_dp", {31'd0, dp}, 32'd0);
        check_eq("rst_digit", {28'd0, digit}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);

        rst_n = 1'b1; load = 1'b0; data = 16'h0000; dp_in = 4'h0;
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

        load_at_fe(16'h1234, 4'h0, 4'h0, 4'h0);
        check_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000);

        // Mid-frame load: old content holds and busy stays up until the frame-end edge
        old_seg[0] = 7'h66; old_seg[1] = 7'h4F; old_seg[2] = 7'h5B; old_seg[3] = 7'h06;
        repeat (5) step();
        data = 16'h5678; load = 1'b1;
        step();
        load = 1'b0;
        check_eq("mid_load_busy", {31'd0, busy}, 32'd1);
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            step();
            check_eq("old_seg_hold", {25'd0, seg}, {25'd0, old_seg[pi]});
            if (mp == 0 && mi == 0) begin
                check_eq("commit_busy", {31'd0, busy}, 32'd0);
                done = 1'b1;
            end else begin
                check_eq("pending_busy", {31'd0, busy}, 32'd1);
            end
        end
        check_eq("commit_reached", {31'd0, done}, 32'd1);
        check_frame(7'h7F, 7'h07, 7'h7D, 7'h6D, 4'b0000);

        lz_en = 1'b1;
        load_at_fe(16'h0070, 4'h0, 4'h0, 4'h0);
        check_frame(7'h3F, 7'h07, 7'h00, 7'h00, 4'b0000);
        lz_en = 1'b0;
        check_frame(7'h3F, 7'h07, 7'h3F, 7'h3F, 4'b0000);

        load_at_fe(16'h4321, 4'b0010, 4'b0100, 4'b0001);
        vis = 0;
        for (int f = 0; f < 4; f++) begin
            e0 = (mph == 1) ? 7'h00 : 7'h06;
            check_frame(e0, 7'h5B, 7'h00, 7'h66, 4'b0010);
            if (seen0 == 7'h06) vis++;
        end
        check_eq("blink_visible_frames", vis, 32'd2);

        repeat (6) step();
        data = 16'h9999; load = 1'b1;
        step();
        load = 1'b0; dp_in = 4'h0; blank_in = 4'h0; blink_in = 4'h0;
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_seg", {25'd0, seg}, 32'h00);
        check_eq("midrst_dp", {31'd0, dp}, 32'd0);
        check_eq("midrst_digit", {28'd0, digit}, 32'd0);
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
        check_eq("midrst_busy_after", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
